// File: rtl/lsu_align.sv
// lsu_align: aligns byte-addressed loads/stores onto a word memory port,
// splitting word-crossing accesses into two word cycles.
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DM_ADDRESS-3:0] mem_waddr,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [15:0]           split_count
);
  localparam int WW = DM_ADDRESS - 2;
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
  state_t state_q, state_d;
  logic load_q, load_d, sign_q, sign_d, split_q, split_d;
  logic [1:0] off_q, off_d;
  logic [2:0] size_q, size_d, req_size;
  logic [WW-1:0] w0_q, w0_d;
  logic [31:0] wdata_q, wdata_d, lo_buf_q, lo_buf_d;
  logic [15:0] split_count_q, split_count_d;
  logic accept, in_lo, in_hi, in_resp;
  logic [3:0] mask;
  logic [7:0] be;
  logic [31:0] smask, lword, ext;
  logic [63:0] sdata;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:DM_ADDRESS];
  assign accept   = req_valid & (state_q == IDLE) & (MemRead | MemWrite);
  assign req_size = (Funct3[1:0] == 2'b00) ? 3'd1 : (Funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign in_lo    = state_q == LO;
  assign in_hi    = state_q == HI;
  assign in_resp  = state_q == RESP;
  always_comb begin
    state_d       = (state_q == IDLE) ? (accept ? LO : IDLE) :
                    (state_q == LO)   ? (split_q ? HI : RESP) :
                    (state_q == HI)   ? RESP : IDLE;
    load_d        = accept ? MemRead : load_q;
    sign_d        = accept ? (Funct3[2:1] == 2'b00) : sign_q;
    off_d         = accept ? req_addr[1:0] : off_q;
    size_d        = accept ? req_size : size_q;
    split_d       = accept ? ({1'b0, req_addr[1:0]} + req_size > 3'd4) : split_q;
    w0_d          = accept ? req_addr[DM_ADDRESS-1:2] : w0_q;
    wdata_d       = accept ? req_wdata : wdata_q;
    lo_buf_d      = (in_hi & load_q) ? mem_rdata : lo_buf_q;
    split_count_d = (in_hi && split_count_q != 16'hFFFF) ? split_count_q + 16'd1 : split_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      load_q        <= 1'b0;
      sign_q        <= 1'b0;
      split_q       <= 1'b0;
      off_q         <= 2'd0;
      size_q        <= 3'd0;
      w0_q          <= '0;
      wdata_q       <= 32'd0;
      lo_buf_q      <= 32'd0;
      split_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      load_q        <= load_d;
      sign_q        <= sign_d;
      split_q       <= split_d;
      off_q         <= off_d;
      size_q        <= size_d;
      w0_q          <= w0_d;
      wdata_q       <= wdata_d;
      lo_buf_q      <= lo_buf_d;
      split_count_q <= split_count_d;
    end
  end
  // Lane placement over a two-word window: low half goes out in LO, high half in HI.
  assign mask  = (size_q == 3'd1) ? 4'b0001 : (size_q == 3'd2) ? 4'b0011 : 4'b1111;
  assign smask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign be    = {4'b0, mask} << off_q;
  assign sdata = {32'b0, wdata_q & smask} << {off_q, 3'b000};
  assign lword = 32'({split_q ? mem_rdata : 32'b0, split_q ? lo_buf_q : mem_rdata} >> {off_q, 3'b000});
  assign ext   = (size_q == 3'd1) ? {{24{sign_q & lword[7]}}, lword[7:0]} :
                 (size_q == 3'd2) ? {{16{sign_q & lword[15]}}, lword[15:0]} : lword;
  assign req_ready   = state_q == IDLE;
  assign mem_waddr   = in_lo ? w0_q : in_hi ? w0_q + WW'(1) : '0;
  assign mem_re      = (in_lo | in_hi) & load_q;
  assign mem_we      = load_q ? 4'b0 : in_lo ? be[3:0] : in_hi ? be[7:4] : 4'b0;
  assign mem_wdata   = load_q ? '0 : in_lo ? sdata[31:0] : in_hi ? sdata[63:32] : '0;
  assign rsp_valid   = in_resp;
  assign rsp_rdata   = (in_resp & load_q) ? ext : '0;
  assign split_count = split_count_q;
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: random and directed loads/stores checked cycle by cycle
// against a byte-level memory model.
module tb_lsu_align;
  logic clk = 0, rst_n = 0, req_valid = 0, MemRead = 0, MemWrite = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0] Funct3 = 0;
  logic req_ready, mem_re, rsp_valid;
  logic [6:0] mem_waddr;
  logic [3:0] mem_we;
  logic [31:0] mem_wdata, mem_rdata, rsp_rdata;
  logic [15:0] split_count;

  lsu_align #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .req_addr(req_addr), .Funct3(Funct3),
    .req_wdata(req_wdata), .mem_waddr(mem_waddr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .split_count(split_count)
  );

  typedef struct {
    int kind;
    logic rdy;
    logic re;
    logic [3:0] we;
    logic [6:0] wa;
    logic [31:0] wd;
    logic rv;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  logic [7:0] ref_b [512];
  logic [31:0] mem_w [128];
  logic [31:0] mem_t;
  int passed = 0, total = 0;
  logic [15:0] model_sc = 0;
  logic [6:0] lo_wa = 0, hi_wa = 0;
  logic [3:0] lo_we = 0, hi_we = 0;
  logic [31:0] lo_wd = 0, hi_wd = 0, last_rsp = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] winit(int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // word memory: synchronous read, byte-lane writes, junk on non-read cycles
  initial begin
    for (int i = 0; i < 128; i++) mem_w[i] = winit(i);
    mem_rdata = 0;
    forever begin
      @(posedge clk);
      mem_rdata <= mem_re ? mem_w[mem_waddr] : $urandom;
      mem_t = mem_w[mem_waddr];
      for (int j = 0; j < 4; j++) if (mem_we[j]) mem_t[8*j +: 8] = mem_wdata[8*j +: 8];
      if (|mem_we) mem_w[mem_waddr] <= mem_t;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      e = '{kind: 3, rdy: 1'b1, re: 1'b0, we: 4'b0, wa: 7'd0, wd: 32'd0, rv: 1'b0, rd: 32'd0};
      if (!rst_n) begin
        q.delete();
        model_sc = 0;
      end else if (q.size() > 0) e = q.pop_front();
      chk("ctl", 64'({req_ready, mem_re, mem_we, rsp_valid}), 64'({e.rdy, e.re, e.we, e.rv}));
      chk("waddr", 64'(mem_waddr), 64'(e.wa));
      chk("wdata", 64'(mem_wdata), 64'(e.wd));
      chk("rdata", 64'(rsp_rdata), 64'(e.rd));
      chk("split_count", 64'(split_count), 64'(model_sc));
      if (e.kind == 0) begin lo_wa = mem_waddr; lo_we = mem_we; lo_wd = mem_wdata; end
      if (e.kind == 1) begin
        hi_wa = mem_waddr; hi_we = mem_we; hi_wd = mem_wdata;
        if (model_sc != 16'hFFFF) model_sc = model_sc + 16'd1;
      end
      if (e.kind == 2) last_rsp = rsp_rdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 10) begin
      req_valid = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
      req_addr = $urandom; Funct3 = 3'($urandom); req_wdata = $urandom;
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
    exp_t e;
    int n, a9, w0, b;
    logic sgn, split;
    logic [3:0] lwe, hwe;
    logic [31:0] ld, hd, val;
    wait_ready();
    req_valid = 1; MemRead = rd; MemWrite = wr; req_addr = a; Funct3 = f3; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    if (!(rd | wr)) return;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    sgn = (f3 == 3'b000) || (f3 == 3'b001);
    a9 = int'(a[8:0]);
    w0 = a9 / 4;
    split = 0; lwe = 0; hwe = 0; ld = 0; hd = 0; val = 0;
    for (int k = 0; k < n; k++) begin
      b = (a9 + k) % 512;
      if (b / 4 != w0) split = 1;
      if (rd) val[8*k +: 8] = ref_b[b];
      else begin
        ref_b[b] = wd[8*k +: 8];
        if (b / 4 == w0) begin lwe[b % 4] = 1; ld[8*(b % 4) +: 8] = wd[8*k +: 8]; end
        else begin hwe[b % 4] = 1; hd[8*(b % 4) +: 8] = wd[8*k +: 8]; end
      end
    end
    if (sgn && n == 1) val = {{24{val[7]}}, val[7:0]};
    if (sgn && n == 2) val = {{16{val[15]}}, val[15:0]};
    e.rdy = 0; e.rv = 0; e.rd = 0; e.re = rd;
    e.kind = 0; e.wa = 7'(w0); e.we = rd ? 4'b0 : lwe; e.wd = rd ? 32'd0 : ld;
    q.push_back(e);
    if (split) begin
      e.kind = 1; e.wa = 7'((w0 + 1) % 128); e.we = rd ? 4'b0 : hwe; e.wd = rd ? 32'd0 : hd;
      q.push_back(e);
    end
    e.kind = 2; e.re = 0; e.we = 0; e.wa = 0; e.wd = 0; e.rv = 1; e.rd = rd ? val : 32'd0;
    q.push_back(e);
  endtask

  task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] wd);
    issue(rd, wr, a, f3, wd);
    wait_ready();
  endtask

  initial begin
    logic [31:0] t, a;
    logic [1:0] st;
    for (int i = 0; i < 128; i++) begin
      t = winit(i);
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = t[8*j +: 8];
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    run(0, 1, 32'h010, 3'b010, 32'hDEADBEEF);
    run(1, 0, 32'h010, 3'b010, 32'h0);
    chk("lw_aligned", 64'(last_rsp), 64'h00000000DEADBEEF);
    chk("lw_waddr", 64'(lo_wa), 64'd4);
    run(0, 1, 32'h010, 3'b010, 32'h80112233);
    run(1, 0, 32'h013, 3'b000, 32'h0);
    chk("lb_sign", 64'(last_rsp), 64'h00000000FFFFFF80);
    run(1, 0, 32'h013, 3'b100, 32'h0);
    chk("lbu_zero", 64'(last_rsp), 64'h0000000000000080);
    run(0, 1, 32'h010, 3'b010, 32'hAABBCCDD);
    run(0, 1, 32'h014, 3'b010, 32'h11223344);
    run(1, 0, 32'h012, 3'b010, 32'h0);
    chk("lw_split", 64'(last_rsp), 64'h000000003344AABB);
    chk("lw_split_words", 64'({lo_wa, hi_wa}), 64'({7'd4, 7'd5}));
    run(0, 1, 32'h00F, 3'b001, 32'h1234BEEF);
    chk("sh_lo", 64'({lo_wa, lo_we, lo_wd}), 64'({7'd3, 4'b1000, 32'hEF000000}));
    chk("sh_hi", 64'({hi_wa, hi_we, hi_wd}), 64'({7'd4, 4'b0001, 32'h000000BE}));
    run(0, 1, 32'h1FE, 3'b010, 32'hCAFEF00D);
    chk("sw_wrap_lo", 64'({lo_wa, lo_we, lo_wd}), 64'({7'd127, 4'b1100, 32'hF00D0000}));
    chk("sw_wrap_hi", 64'({hi_wa, hi_we, hi_wd}), 64'({7'd0, 4'b0011, 32'h0000CAFE}));
    run(1, 0, 32'h1FE, 3'b010, 32'h0);
    chk("lw_wrap", 64'(last_rsp), 64'h00000000CAFEF00D);
    run(0, 0, 32'h010, 3'b010, 32'h0);
    issue(1, 0, 32'h012, 3'b010, 32'h0);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    run(1, 1, 32'h010, 3'b010, 32'h0);
    chk("both_strobes_load", 64'(last_rsp), 64'h00000000AABBCCBE);
    chk("both_strobes_no_we", 64'(lo_we), 64'd0);
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[8:2] = 7'h7F;
      st = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      issue(st[0], st[1], a, 3'($urandom), $urandom);
    end
    wait_ready();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
